// File: rtl/mac_stream_if.sv
// Stream bundle for mac_stream: operand-pair input stream and result output stream.
// slave is the block's view; master is the upstream/downstream driver view.
interface mac_stream_if #(
    parameter int INW  = 12,
    parameter int OUTW = 24
);
    logic [2*INW-1:0] IN_AXIS_TDATA;
    logic             IN_AXIS_TVALID;
    logic             IN_AXIS_TREADY;
    logic [OUTW-1:0]  OUT_AXIS_TDATA;
    logic             OUT_AXIS_TVALID;
    logic             OUT_AXIS_TREADY;

    modport slave (
        input  IN_AXIS_TDATA,
        input  IN_AXIS_TVALID,
        output IN_AXIS_TREADY,
        output OUT_AXIS_TDATA,
        output OUT_AXIS_TVALID,
        input  OUT_AXIS_TREADY
    );

    modport master (
        output IN_AXIS_TDATA,
        output IN_AXIS_TVALID,
        input  IN_AXIS_TREADY,
        input  OUT_AXIS_TDATA,
        input  OUT_AXIS_TVALID,
        output OUT_AXIS_TREADY
    );
endinterface

// File: rtl/mac_stream.sv
// Streaming K-term signed dot product: product stage P feeds accumulate stage A,
// result held in an output register until the downstream FIFO takes it.
module mac_stream #(
    parameter int INW  = 12,
    parameter int OUTW = 24,
    parameter int K    = 4
) (
    input  logic          clk,
    input  logic          reset,
    mac_stream_if.slave   bus
);
    localparam int            CW   = (K > 1) ? $clog2(K) : 1;
    localparam logic [CW-1:0] LAST = CW'(K - 1);

    logic [CW-1:0]   cnt_q, cnt_d;
    logic [OUTW-1:0] prod_r_q, prod_r_d;
    logic            prod_v_q, prod_v_d;
    logic            prod_last_q, prod_last_d;
    logic [OUTW-1:0] acc_q, acc_d;
    logic [OUTW-1:0] out_data_q, out_data_d;
    logic            out_valid_q, out_valid_d;

    logic [INW-1:0]  op_a, op_b;
    logic [OUTW-1:0] a_ext, b_ext, prod_full, sum;
    logic            stall, accept, xfer;

    assign op_a = bus.IN_AXIS_TDATA[INW-1:0];
    assign op_b = bus.IN_AXIS_TDATA[2*INW-1:INW];

    // Multiplying the OUTW-wide sign extensions gives the exact signed product
    // modulo 2^OUTW, which is all the wrapping accumulator needs.
    assign a_ext     = {{(OUTW-INW){op_a[INW-1]}}, op_a};
    assign b_ext     = {{(OUTW-INW){op_b[INW-1]}}, op_b};
    assign prod_full = a_ext * b_ext;
    assign sum       = acc_q + prod_r_q;

    // Only a completed result blocked behind a held output can stall the pipe.
    assign stall  = prod_v_q && prod_last_q && out_valid_q && !bus.OUT_AXIS_TREADY;
    assign accept = bus.IN_AXIS_TVALID && !stall;
    assign xfer   = out_valid_q && bus.OUT_AXIS_TREADY;

    assign bus.IN_AXIS_TREADY  = !stall;
    assign bus.OUT_AXIS_TDATA  = out_data_q;
    assign bus.OUT_AXIS_TVALID = out_valid_q;

    always_comb begin
        cnt_d       = cnt_q;
        prod_r_d    = prod_r_q;
        prod_v_d    = prod_v_q;
        prod_last_d = prod_last_q;
        acc_d       = acc_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;

        if (accept) begin
            cnt_d       = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
            prod_r_d    = prod_full;
            prod_v_d    = 1'b1;
            prod_last_d = (cnt_q == LAST);
        end else if (!stall) begin
            prod_v_d = 1'b0;
        end

        if (prod_v_q && !prod_last_q) begin
            acc_d = sum;
        end

        // A new result may load in the same cycle the previous one transfers.
        if (prod_v_q && prod_last_q && !stall) begin
            out_data_d  = sum;
            out_valid_d = 1'b1;
            acc_d       = '0;
        end else if (xfer) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q       <= '0;
            prod_r_q    <= '0;
            prod_v_q    <= 1'b0;
            prod_last_q <= 1'b0;
            acc_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            prod_r_q    <= prod_r_d;
            prod_v_q    <= prod_v_d;
            prod_last_q <= prod_last_d;
            acc_q       <= acc_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end
endmodule

// File: doc/mac_stream.md
MAC_STREAM -- requirements
Module: mac_stream

Interface
REQ-001 Parameter INW, default 12: signed width of each input operand.
REQ-002 Parameter OUTW, default 24: width of accumulated result; SHALL satisfy OUTW >= 2*INW.
REQ-003 Parameter K, default 4: number of products summed per result; SHALL be >= 2.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 IN_AXIS_TDATA  input  2*INW  operand pair; a = [INW-1:0], b = [2*INW-1:INW], both two's complement.
REQ-007 IN_AXIS_TVALID  input  1  upstream beat valid.
REQ-008 IN_AXIS_TREADY  output  1  block can accept a beat this cycle.
REQ-009 OUT_AXIS_TDATA  output  OUTW  dot-product result, feeds the output FIFO.
REQ-010 OUT_AXIS_TVALID  output  1  result valid.
REQ-011 OUT_AXIS_TREADY  input  1  downstream FIFO can accept.

Function
REQ-012 Beat accepted iff IN_AXIS_TVALID && IN_AXIS_TREADY; result transferred iff OUT_AXIS_TVALID && OUT_AXIS_TREADY.
REQ-013 Beat counter cnt, 0..K-1, SHALL increment per accepted beat and wrap K-1 -> 0; beat with cnt==K-1 is "last".
REQ-014 Stage P: on accepted beat, prod_r <= sign-extend(a*b) to OUTW, prod_v <= 1, prod_last <= (cnt==K-1); with no accepted beat and no stall, prod_v <= 0.
REQ-015 Stage A: when prod_v and not last, acc <= acc + prod_r (mod 2^OUTW).
REQ-016 Stage A: when prod_v and last and not stalled, OUT_AXIS_TDATA <= acc + prod_r, OUT_AXIS_TVALID <= 1, acc <= 0.
REQ-017 stall = prod_v && prod_last && OUT_AXIS_TVALID && !OUT_AXIS_TREADY; during stall, prod_r/prod_v/prod_last/acc/cnt SHALL hold.
REQ-018 IN_AXIS_TREADY = !stall (combinational); otherwise 1, including when reset is deasserted.
REQ-019 Latency: last beat accepted in cycle t -> OUT_AXIS_TVALID high in cycle t+2 when unstalled.
REQ-020 Throughput: one beat per cycle sustained with OUT_AXIS_TREADY=1; back-to-back vectors SHALL need no bubble.
REQ-021 OUT_AXIS_TVALID held with OUT_AXIS_TDATA stable until transfer; after transfer with no new result loading, OUT_AXIS_TVALID <= 0.
REQ-022 Transfer and new result load in the same cycle: OUT_AXIS_TVALID stays 1, OUT_AXIS_TDATA takes the new result.
REQ-023 Arithmetic wraps modulo 2^OUTW; no saturation, no overflow flag.
REQ-024 IN_AXIS_TVALID gaps SHALL NOT affect the sum; only accepted beats count.

Reset
REQ-025 On reset: cnt=0, acc=0, prod_v=0, prod_last=0, prod_r=0, OUT_AXIS_TVALID=0, OUT_AXIS_TDATA=0.
REQ-026 Reset mid-vector SHALL discard partial sums and any pending or held result; the next accepted beat is beat 0.
REQ-027 Reset overrides all handshakes in the same cycle; no beat accepted or result transferred counts during reset.

Verification (INW=12, OUTW=24, K=4)
REQ-028 Pairs (1,2),(3,4),(5,6),(7,8) back-to-back, OUT_AXIS_TREADY=1 -> OUT_AXIS_TDATA=100, TVALID high for exactly one cycle, 2 cycles after the 4th beat.
REQ-029 (-3,5) x4 -> OUT_AXIS_TDATA=24'hFFFFC4 (-60); same (1..8) vector with random TVALID gaps -> 100.
REQ-030 (-2048,-2048) x4 -> sum 2^24 wraps to OUT_AXIS_TDATA=0, TVALID=1.
REQ-031 Two vectors back-to-back ((1,1)x4 then (2,2)x4), OUT_AXIS_TREADY=0 -> first result 4 held stable; IN_AXIS_TREADY drops while the 2nd last product is pending; raise TREADY -> 4 transfers, then 16 next cycle, no beat lost.
REQ-032 Two beats of (9,9), reset for one cycle, then (1,1)x4 -> single result 4, no output from the aborted vector.
REQ-033 Bench SHALL check every transfer against a scoreboard model and assert TDATA stability while TVALID && !TREADY.
